iter_shl_unit: RTL and testbench

//  Multi-cycle left-shift unit: the left-direction partner of the combinational arithmetic right shifter.

---
 rtl/iter_shl_unit.sv | 58 +++++
 tb/tb_iter_shl_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/iter_shl_unit.sv
// Iterative left shifter: ans = a << b, one bit per cycle, with signed-overflow detection.
// Start/busy/done handshake; operands are captured on the accepted start only.
module iter_shl_unit #(
    parameter int WIDTH = 4,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic             ovf
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= a;
                        ovf <= 1'b0;
                        cnt <= b;
                        state <= (b == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // sign bit changes on this step -> result no longer equals a*2^b
                    ovf <= ovf | (acc[WIDTH-1] ^ acc[WIDTH-2]);
                    acc <= {acc[WIDTH-2:0], 1'b0};
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign ans  = acc;

endmodule

// File: tb/tb_iter_shl_unit.sv
// Self-checking bench for iter_shl_unit: directed cases plus random ops against an arithmetic model.
module tb_iter_shl_unit;

    localparam int W  = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
    logic [SW-1:0] b;
    logic          busy, done, ovf;
    logic [W-1:0]  ans;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] last_ans;
    logic         last_ovf;

    iter_shl_unit #(.WIDTH(W), .SHW(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .ans(ans), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Result is a*2^b truncated to W bits; overflow iff the truncated value read signed differs.
    function automatic void model(input logic [W-1:0] oa, input logic [SW-1:0] ob,
                                  output logic [W-1:0] ea, output logic ev);
        longint      prod;
        logic [63:0] p;
        prod = longint'($signed(oa)) * (longint'(1) << ob);
        p    = prod;
        ea   = p[W-1:0];
        ev   = (longint'($signed(ea)) != prod);
    endfunction

    // Entered and left at the negedge of an IDLE cycle, so consecutive calls are back-to-back.
    task automatic run_op(input logic [W-1:0] oa, input logic [SW-1:0] ob, input bit mid_pulse);
        logic [W-1:0] ea;
        logic         ev;
        int           cyc;
        bit           seen;
        model(oa, ob, ea, ev);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("held_ans", ans, last_ans);
        chk("held_ovf", ovf, last_ovf);
        start = 1'b1; a = oa; b = ob;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = SW'($urandom);
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mid_pulse && cyc == 2) begin start = 1'b1; a = 4'b0001; b = 4'b0001; end
            if (mid_pulse && cyc == 3) start = 1'b0;
            chk("busy_run", busy, 1);
            if (done) seen = 1;
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", cyc, ob + 1);
        chk("ans", ans, ea);
        chk("ovf", ovf, ev);
        last_ans = ea;
        last_ovf = ev;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        last_ans = '0; last_ovf = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ans", ans, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b1;
        @(negedge clk);

        run_op(4'b0011, 4'd2, 0);
        run_op(4'b1111, 4'd3, 0);
        run_op(4'b1010, 4'd0, 0);
        @(negedge clk);
        chk("hold_ans", ans, 4'b1010);
        run_op(4'b0001, 4'd9, 0);
        run_op(4'b0000, 4'd15, 0);
        run_op(4'b0011, 4'd3, 1);
        run_op(4'b0101, 4'd1, 0);

        // reset in the middle of a shift drops the op
        start = 1'b1; a = 4'b0110; b = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_ans", ans, 0);
        chk("mrst_ovf", ovf, 0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_done", done, 0);
        end
        last_ans = '0; last_ovf = 1'b0;
        run_op(4'b0111, 4'd2, 0);

        for (int i = 0; i < 30; i++)
            run_op(W'($urandom), SW'($urandom_range(0, 15)), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
